// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the execute stage: R-type function codes and the
// state encoding of the multi-cycle multiply/divide sequencer.
package muldiv_seq_pkg;

  // R-type funct field values handled elsewhere in the execute stage
  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  // Function codes owned by the multiply/divide sequencer
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO registers.
// Multiply is shift-add, divide is restoring; both share one 2*WIDTH-bit
// working register and run on operand magnitudes, with the sign applied in FIX.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, fncode   request strobe and R-type funct selecting the operation
//   op_a, op_b      rs / rt operand values
//   busy            high from the accept edge until the commit edge
//   done            one-cycle pulse after HI/LO commit
//   hi, lo          architectural HI / LO registers
//
// Handshake: a request is taken only when start=1 in IDLE with a recognised
// fncode; there is no ready signal, the core must hold off while busy=1 and
// any start seen outside IDLE is dropped.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t          state;
  logic [ITER_CNT_W-1:0]  count;
  logic [2*WIDTH-1:0]     work;    // MUL: {product hi, multiplier/product lo}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]       opnd;    // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]       a_raw;   // raw dividend, returned in HI on divide-by-zero
  logic                   neg_q;
  logic                   neg_r;
  logic                   is_div;
  logic                   b_zero;

  // Operand conditioning at accept time
  logic             is_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    sa        = is_signed & op_a[WIDTH-1];
    sb        = is_signed & op_b[WIDTH-1];
    a_mag     = sa ? (~op_a + 1'b1) : op_a;
    b_mag     = sb ? (~op_b + 1'b1) : op_b;
  end

  // Shared shift datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;   // partial remainder, one bit wider so the borrow survives
  logic [WIDTH:0]     diff;
  logic               qbit;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = work[0] ? {mul_sum, work[WIDTH-1:1]}
                       : {1'b0, work[2*WIDTH-1:WIDTH], work[WIDTH-1:1]};

    // Remainder stays below the divisor, so its top bit of diff is the sign
    shifted  = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    qbit     = ~diff[WIDTH];
    new_rem  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_next = {new_rem, work[WIDTH-2:0], qbit};

    prod_fix = neg_q ? (~work + 1'b1) : work;
    quo_fix  = neg_q ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
    rem_fix  = neg_r ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      work   <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            case (fncode)
              FUNCT_MULT, FUNCT_MULTU: begin
                work   <= {{WIDTH{1'b0}}, b_mag};
                opnd   <= a_mag;
                a_raw  <= op_a;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                is_div <= 1'b0;
                b_zero <= (op_b == '0);
                count  <= ITER_CNT_W'(WIDTH);
                busy   <= 1'b1;
                state  <= MUL;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                work   <= {{WIDTH{1'b0}}, a_mag};
                opnd   <= b_mag;
                a_raw  <= op_a;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                is_div <= 1'b1;
                b_zero <= (op_b == '0);
                count  <= ITER_CNT_W'(WIDTH);
                busy   <= 1'b1;
                state  <= DIV;
              end
              FUNCT_MTHI: hi <= op_a;
              FUNCT_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          work  <= mul_next;
          count <= count - 1'b1;
          if (count == ITER_CNT_W'(1)) state <= FIX;
        end
        DIV: begin
          work  <= div_next;
          count <= count - 1'b1;
          if (count == ITER_CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, plus owner of the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. The decoded R-type function code selects the operation.
- Raises `busy` so the core stalls MFHI/MFLO and any new mul/div until the result is committed.
- Uses one shared 64-bit shift datapath: shift-add for multiply, restoring subtract-shift for divide.

Parameters:
- WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits.
- ITER_CNT_W, 6, iteration counter width. Must satisfy ITER_CNT_W ≥ clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request valid; qualified by fncode
- fncode  input  6  R-type funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
- op_a  input  WIDTH  rs value (multiplicand, dividend, or MTHI/MTLO data)
- op_b  input  WIDTH  rt value (multiplier or divisor)
- busy  output  1  high from the accept edge until the commit edge
- done  output  1  one-cycle pulse in the cycle after HI/LO commit
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; hi=0; lo=0; counter and working registers cleared.
  - Reset asserted mid-operation aborts the operation with no partial commit.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start && fncode∈{MULT,MULTU}: latch |op_a| and |op_b| (magnitudes for signed, raw values for unsigned). Latch sign flags (neg_q = sa^sb, neg_r = sa; 0 for unsigned). Set counter = WIDTH. Go to MUL; busy=1 next cycle.
  - start && fncode∈{DIV,DIVU}: same latching, go to DIV.
  - start && MTHI: hi←op_a next edge. start && MTLO: lo←op_a next edge. Both are single-cycle; busy stays 0.
  - Any other fncode, or start=0: no action.
- MUL: one multiplier bit per cycle (shift-add). Counter decrements; at 0, go to FIX.
- DIV: one quotient bit per cycle (restoring). Counter decrements; at 0, go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation: 64-bit product if neg_q; quotient if neg_q; remainder if neg_r.
  - Commit: MUL → {hi,lo}=product. DIV → lo=quotient, hi=remainder.
  - Go to DONE.
- DONE: done=1 and busy=0 for this one cycle, then go to IDLE. A start sampled in DONE is ignored.
- Latency: accept at edge N; commit at edge N+WIDTH+1 (N+33 for WIDTH=32); done high for the following cycle.
- start while busy=1: ignored. No queueing, and operands are not re-latched.
- Division by zero (op_b=0, signed or unsigned):
  - Runs the full latency; the sign fix is suppressed.
  - Result is lo=all-ones and hi=op_a as latched raw.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Width rules:
  - Product is 2·WIDTH bits, computed exactly.
  - The partial-remainder register is WIDTH+1 bits, so the subtract borrow is never lost.
- hi and lo change only on: reset, MTHI/MTLO in IDLE, or the FIX commit.

Decomposition:
- Shared package: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO constants, alongside the existing FUNCT_*. Also the state typedef muldiv_state_t {IDLE, MUL, DIV, FIX, DONE}.
- No sub-module. The single shared shift datapath plus negation logic stays inline in muldiv_seq.

Test Plan:
- MULT op_a=0xFFFFFFFE, op_b=3 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses exactly once; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → hi and lo each updated one edge after its start; busy never asserts.
- MULTU 5×6 started, then start with DIVU 100/3 at cycle 10 → second request ignored; final hi=0, lo=30.
- MULT in flight, rst_n pulsed low at cycle 15 (asynchronous, mid-cycle) → hi=lo=0, busy=0 immediately. A new MULTU 2×3 after release gives lo=6.
